// File: rtl/conv_sched.sv
// conv_sched: row-major window scheduler that drives a convolution engine and writes each result to an output map.
// Optional ReLU clamp on captured results is enabled by defining CONV_SCHED_RELU_EN.
module conv_sched #(
    parameter int SIZE      = 7,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                        i_clock,
    input  logic                        i_nreset,
    input  logic                        i_start,
    input  logic                        i_abort,
    output logic                        o_eng_start,
    output logic        [WIDTH_BIT-1:0] o_eng_row,
    output logic        [WIDTH_BIT-1:0] o_eng_col,
    input  logic                        i_eng_valid,
    input  logic signed [WIDTH_BIT-1:0] i_eng_result,
    output logic                        o_wr_en,
    output logic        [WIDTH_BIT-1:0] o_wr_row,
    output logic        [WIDTH_BIT-1:0] o_wr_col,
    output logic signed [WIDTH_BIT-1:0] o_wr_data,
    input  logic                        i_wr_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int OUT   = SIZE - SIZEKer + 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WIDTH_BIT-1:0] LAST_IDX = WIDTH_BIT'(OUT - 1);
    localparam logic [CNT_W-1:0]     TO_LAST  = CNT_W'(TIMEOUT - 1);

    // Reject geometries whose last output index cannot be held in the index registers.
    generate
        if (SIZEKer < 1 || SIZEKer > SIZE || TIMEOUT < 1 ||
            (WIDTH_BIT < 31 && (OUT - 1) >= (1 << WIDTH_BIT))) begin : g_bad_params
            $error("conv_sched: invalid SIZE/SIZEKer/WIDTH_BIT/TIMEOUT combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic        [WIDTH_BIT-1:0]   r_row;
    logic        [WIDTH_BIT-1:0]   r_col;
    logic        [WIDTH_BIT-1:0]   w_row_next;
    logic        [WIDTH_BIT-1:0]   w_col_next;
    logic        [CNT_W-1:0]       r_cnt;
    logic        [CNT_W-1:0]       w_cnt_next;
    logic signed [WIDTH_BIT-1:0]   r_wr_data;
    logic signed [WIDTH_BIT-1:0]   w_wr_data_next;
    logic signed [WIDTH_BIT-1:0]   w_captured;
    logic                          r_err;
    logic                          w_err_next;
    logic                          w_eng_start;
    logic                          w_wr_en;
    logic                          w_done;

`ifdef CONV_SCHED_RELU_EN
    assign w_captured = i_eng_result[WIDTH_BIT-1] ? '0 : i_eng_result;
`else
    assign w_captured = i_eng_result;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_row_next     = r_row;
        w_col_next     = r_col;
        w_cnt_next     = r_cnt;
        w_wr_data_next = r_wr_data;
        w_err_next     = r_err;
        w_eng_start    = 1'b0;
        w_wr_en        = 1'b0;
        w_done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_row_next   = '0;
                    w_col_next   = '0;
                    w_err_next   = 1'b0;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_eng_start  = 1'b1;
                w_cnt_next   = '0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (i_eng_valid) begin
                    w_wr_data_next = w_captured;
                    w_state_next   = S_WRITE;
                end else if (r_cnt == TO_LAST) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WRITE: begin
                w_wr_en = 1'b1;
                if (i_wr_ready) begin
                    if (r_col == LAST_IDX) begin
                        if (r_row == LAST_IDX) begin
                            w_state_next = S_FIN;
                        end else begin
                            w_col_next   = '0;
                            w_row_next   = r_row + 1'b1;
                            w_state_next = S_ISSUE;
                        end
                    end else begin
                        w_col_next   = r_col + 1'b1;
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Abort squashes any strobe of the current cycle so no half-finished transaction escapes.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_next   = S_IDLE;
            w_row_next     = r_row;
            w_col_next     = r_col;
            w_cnt_next     = r_cnt;
            w_wr_data_next = r_wr_data;
            w_err_next     = r_err;
            w_eng_start    = 1'b0;
            w_wr_en        = 1'b0;
            w_done         = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_nreset) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_row     <= w_row_next;
            r_col     <= w_col_next;
            r_cnt     <= w_cnt_next;
            r_wr_data <= w_wr_data_next;
            r_err     <= w_err_next;
        end
    end

    assign o_eng_start = w_eng_start;
    assign o_eng_row   = r_row;
    assign o_eng_col   = r_col;
    assign o_wr_en     = w_wr_en;
    assign o_wr_row    = r_row;
    assign o_wr_col    = r_col;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = w_done;
    assign o_err       = r_err;

endmodule
